vec_concat_unit: RTL and testbench

Registered vector concatenation/repacking block. It takes six 5-bit fields, appends a 2-bit constant pad, and splits the resulting 32-bit word into four registered 8-bit output bytes. It sits between narrow field producers and byte-oriented downstream logic. A valid handshake and a change-detect pulse are included.

---
 rtl/vec_concat_unit.sv | 114 +++++++++++
 tb/tb_vec_concat_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/vec_concat_unit.sv
// vec_concat_unit: packs six 5-bit fields and a 2-bit pad into a 32-bit word.
// The word is split into four registered bytes, w (MSB) through z (LSB).
// out_valid marks the cycle after a capture. changed is high when that
// capture differed from the word that was held before it.
// Optional build macro VEC_CONCAT_UNIT_PARITY_EN adds the par output.
// par holds the even parity of each byte and is registered with the bytes.

// One byte lane of the held word.
// diff compares the incoming byte against the byte currently held, so the
// top level can form its change flag from the pre-capture value.
module vec_concat_unit_lane #(
    parameter int          VEC_W    = 8,
    parameter logic [VEC_W-1:0] RST_BYTE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap,
    input  logic [VEC_W-1:0] d,
    output logic [VEC_W-1:0] q,
`ifdef VEC_CONCAT_UNIT_PARITY_EN
    output logic             par,
`endif
    output logic             diff
);
    // Compare against the held byte. X/Z inputs propagate here on purpose.
    assign diff = (d != q);

    // Load the byte on capture. Otherwise hold it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= RST_BYTE;
        else if (cap) q <= d;
    end

`ifdef VEC_CONCAT_UNIT_PARITY_EN
    // Register the parity with the byte so the two stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   par <= ^RST_BYTE;
        else if (cap) par <= ^d;
    end
`endif
endmodule

module vec_concat_unit #(
    parameter logic [1:0]  PAD        = 2'b11,
    parameter logic [31:0] RESET_WORD = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic [4:0] c,
    input  logic [4:0] d,
    input  logic [4:0] e,
    input  logic [4:0] f,
    output logic [7:0] w,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [7:0] z,
`ifdef VEC_CONCAT_UNIT_PARITY_EN
    output logic [3:0] par,
`endif
    output logic       out_valid,
    output logic       changed
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int STAGES    = 1;

    logic [NUM_LANES-1:0][VEC_W-1:0] lane_d;
    logic [NUM_LANES-1:0][VEC_W-1:0] lane_q;
    logic [NUM_LANES-1:0]            lane_diff;
    logic [STAGES:0]                 vld_pipe;
    logic                            chg_q;

    // Pack the fields MSB-first. Lane 3 carries a[4] in its top bit and lane 0
    // carries the pad in its bottom bits.
    assign lane_d = {a, b, c, d, e, f, PAD};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        vec_concat_unit_lane #(
            .VEC_W    (VEC_W),
            .RST_BYTE (RESET_WORD[i*VEC_W +: VEC_W])
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .cap   (in_valid),
            .d     (lane_d[i]),
            .q     (lane_q[i]),
`ifdef VEC_CONCAT_UNIT_PARITY_EN
            .par   (par[i]),
`endif
            .diff  (lane_diff[i])
        );
    end

    assign vld_pipe[0] = in_valid;

    // Delay the valid bit by one stage so it lines up with the captured bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe[STAGES:1] <= '0;
        else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    // Pulse changed only on a capture, using the word held before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chg_q <= 1'b0;
        else        chg_q <= in_valid & (|lane_diff);
    end

    assign {w, x, y, z} = lane_q;
    assign out_valid    = vld_pipe[STAGES];
    assign changed      = chg_q;
endmodule

// File: tb/tb_vec_concat_unit.sv
// Directed bench for vec_concat_unit with a scoreboard queue.
// Each step computes the expected outputs from a small reference model and
// pushes them to the queue. After the next rising edge the bench pops the
// entry and compares it against the outputs.
// The bench builds with or without VEC_CONCAT_UNIT_PARITY_EN.
module tb_vec_concat_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] a = '0, b = '0, c = '0, d = '0, e = '0, f = '0;
    logic [7:0] w, x, y, z;
    logic       out_valid, changed;
`ifdef VEC_CONCAT_UNIT_PARITY_EN
    logic [3:0] par;
`endif

    typedef struct {
        logic [31:0] word;
        logic        ov;
        logic        ch;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] held = 32'h0;
    int          compared = 0;
    int          mismatched = 0;

    vec_concat_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .w         (w),
        .x         (x),
        .y         (y),
        .z         (z),
`ifdef VEC_CONCAT_UNIT_PARITY_EN
        .par       (par),
`endif
        .out_valid (out_valid),
        .changed   (changed)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle from a negedge and push the expected result.
    // Then pop and compare after the rising edge, and return on the next negedge.
    task automatic step(input string tag, input logic v, input logic [29:0] fw);
        exp_t        ex;
        exp_t        got;
        logic [31:0] nw;
        {a, b, c, d, e, f} = fw;
        in_valid = v;
        nw      = {fw, 2'b11};
        ex.word = v ? nw : held;
        ex.ov   = v;
        ex.ch   = v && (nw != held);
        sb.push_back(ex);
        held = ex.word;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            got = sb.pop_front();
            chk32({tag, ".word"}, {w, x, y, z}, got.word);
            chk1({tag, ".out_valid"}, out_valid, got.ov);
            chk1({tag, ".changed"}, changed, got.ch);
`ifdef VEC_CONCAT_UNIT_PARITY_EN
            chk32({tag, ".par"}, {28'h0, par},
                  {28'h0, ^got.word[31:24], ^got.word[23:16], ^got.word[15:8], ^got.word[7:0]});
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk32("rst.word", {w, x, y, z}, 32'h0);
        chk1("rst.out_valid", out_valid, 1'b0);
        chk1("rst.changed", changed, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        step("idle0", 1'b0, 30'h0);
        step("zero", 1'b1, 30'h0);
        chk32("zero.bytes", {w, x, y, z}, 32'h0000_0003);
        step("x45", 1'b1, {5'h00, 5'h01, 5'h02, 5'h13, 5'h00, 5'h00});
        chk32("x45.bytes", {w, x, y, z}, 32'h0045_3003);
`ifdef VEC_CONCAT_UNIT_PARITY_EN
        chk32("x45.par_const", {28'h0, par}, 32'h4);
`endif
        step("x45.again", 1'b1, {5'h00, 5'h01, 5'h02, 5'h13, 5'h00, 5'h00});
        chk1("x45.again_nochg", changed, 1'b0);
        step("a14", 1'b1, {5'h14, 25'h0});
        chk32("a14.bytes", {w, x, y, z}, 32'hA000_0003);
        step("f1f", 1'b1, {25'h0, 5'h1F});
        chk32("f1f.bytes", {w, x, y, z}, 32'h0000_007F);
        step("ones", 1'b1, {6{5'h1F}});
        chk32("ones.bytes", {w, x, y, z}, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 30'h0);
        chk32("hold.bytes", {w, x, y, z}, 32'hFFFF_FFFF);

        // Mid-cycle reset clears the outputs without a clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk32("midrst.word", {w, x, y, z}, 32'h0);
        chk1("midrst.out_valid", out_valid, 1'b0);
        chk1("midrst.changed", changed, 1'b0);
        held = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step("post_rst", 1'b1, 30'h0);
        step("rand", 1'b1, 30'($urandom));
        step("rand2", 1'b1, 30'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
